// File: rtl/led_pattern_checker_if.sv
// Bus bundle between the LED pattern source and the pattern checker.
// The source (or bench) drives led_i; the checker returns status and counters.
interface led_pattern_checker_if;
  logic [11:0] led_i;
  logic        locked;
  logic        mode_o;
  logic [3:0]  phase_o;
  logic        err_o;
  logic [7:0]  err_cnt;
  logic [7:0]  seq_cnt;

  modport master (
    output led_i,
    input  locked, mode_o, phase_o, err_o, err_cnt, seq_cnt
  );

  modport slave (
    input  led_i,
    output locked, mode_o, phase_o, err_o, err_cnt, seq_cnt
  );
endinterface

// File: rtl/led_pattern_checker.sv
// Receive-side checker for the 12-bit running-LED stream. Decodes each
// (previous, current) pattern pair into mode/phase, locks after LOCK_CNT
// consecutive correct successors, and flags every loss of lock.
//
// state  | meaning
// SEARCH | no reference yet; waiting for any legal pattern pair
// VERIFY | reference held; counting consecutive correct successors
// LOCKED | stream verified; every pair must be the expected successor
module led_pattern_checker #(
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_pattern_checker_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  logic [11:0] r_cur, r_prv;
  logic [1:0]  r_fill;
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_match, w_match_nxt;
  logic        r_mode, w_mode_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic        r_locked, w_locked_nxt;
  logic        r_mode_o, w_mode_o_nxt;
  logic [3:0]  r_phase, w_phase_nxt;
  logic        r_err, w_err_nxt;
  logic [7:0]  r_err_cnt, w_err_cnt_nxt;
  logic [7:0]  r_seq, w_seq_nxt;

  logic        w_pair_vld, w_pair_ok, w_dec_mode, w_hit;
  logic [3:0]  w_dec_idx, w_exp_idx;

  function automatic logic [11:0] fill_pat(input logic [3:0] k);
    case (k)
      4'd0:    fill_pat = 12'h000;
      4'd1:    fill_pat = 12'h060;
      4'd2:    fill_pat = 12'h0F0;
      4'd3:    fill_pat = 12'h1F8;
      4'd4:    fill_pat = 12'h3FC;
      4'd5:    fill_pat = 12'h7FE;
      default: fill_pat = 12'hFFF;
    endcase
  endfunction

  function automatic logic [11:0] bounce_pat(input logic [3:0] k);
    case (k)
      4'd0:    bounce_pat = 12'h801;
      4'd1:    bounce_pat = 12'h402;
      4'd2:    bounce_pat = 12'h204;
      4'd3:    bounce_pat = 12'h108;
      4'd4:    bounce_pat = 12'h090;
      4'd5:    bounce_pat = 12'h060;
      4'd6:    bounce_pat = 12'h090;
      4'd7:    bounce_pat = 12'h108;
      4'd8:    bounce_pat = 12'h204;
      default: bounce_pat = 12'h402;
    endcase
  endfunction

  function automatic logic [3:0] fill_succ(input logic [3:0] k);
    fill_succ = (k == 4'd6) ? 4'd0 : k + 4'd1;
  endfunction

  function automatic logic [3:0] bounce_succ(input logic [3:0] k);
    bounce_succ = (k == 4'd9) ? 4'd0 : k + 4'd1;
  endfunction

  // Capture pipeline: newest pattern, previous pattern, and fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur  <= 12'h000;
      r_prv  <= 12'h000;
      r_fill <= 2'd0;
    end else begin
      r_cur  <= bus.led_i;
      r_prv  <= r_cur;
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
    end
  end

  // Pair decode; single patterns are ambiguous, so only legal transitions
  // count. An X/Z bit never satisfies an equality, so pair_ok stays 0.
  always_comb begin
    w_pair_ok  = 1'b0;
    w_dec_mode = 1'b0;
    w_dec_idx  = 4'd0;
    for (int k = 0; k < 7; k++) begin
      if (r_prv == fill_pat(4'(k)) && r_cur == fill_pat(fill_succ(4'(k)))) begin
        w_pair_ok  = 1'b1;
        w_dec_mode = 1'b1;
        w_dec_idx  = fill_succ(4'(k));
      end
    end
    for (int k = 0; k < 10; k++) begin
      if (r_prv == bounce_pat(4'(k)) && r_cur == bounce_pat(bounce_succ(4'(k)))) begin
        w_pair_ok  = 1'b1;
        w_dec_mode = 1'b0;
        w_dec_idx  = bounce_succ(4'(k));
      end
    end
  end

  assign w_pair_vld = (r_fill == 2'd2);
  assign w_exp_idx  = r_mode ? fill_succ(r_idx) : bounce_succ(r_idx);
  assign w_hit      = w_pair_vld && w_pair_ok && (w_dec_mode == r_mode) &&
                      (w_dec_idx == w_exp_idx);

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SEARCH;
      r_match   <= 4'd0;
      r_mode    <= 1'b0;
      r_idx     <= 4'd0;
      r_locked  <= 1'b0;
      r_mode_o  <= 1'b0;
      r_phase   <= 4'd0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
      r_seq     <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_match   <= w_match_nxt;
      r_mode    <= w_mode_nxt;
      r_idx     <= w_idx_nxt;
      r_locked  <= w_locked_nxt;
      r_mode_o  <= w_mode_o_nxt;
      r_phase   <= w_phase_nxt;
      r_err     <= w_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      r_seq     <= w_seq_nxt;
    end
  end

  // Next-state and output decisions from the pre-edge pipeline contents.
  always_comb begin
    w_state_nxt   = r_state;
    w_match_nxt   = r_match;
    w_mode_nxt    = r_mode;
    w_idx_nxt     = r_idx;
    w_locked_nxt  = r_locked;
    w_mode_o_nxt  = r_mode_o;
    w_phase_nxt   = r_phase;
    w_err_nxt     = 1'b0;
    w_err_cnt_nxt = r_err_cnt;
    w_seq_nxt     = r_seq;
    case (r_state)
      SEARCH: begin
        if (w_pair_vld && w_pair_ok) begin
          w_mode_nxt  = w_dec_mode;
          w_idx_nxt   = w_dec_idx;
          w_match_nxt = 4'd1;
          if (LOCK_N == 4'd1) begin
            w_state_nxt  = LOCKED;
            w_locked_nxt = 1'b1;
            w_mode_o_nxt = w_dec_mode;
            w_phase_nxt  = w_dec_idx;
          end else begin
            w_state_nxt = VERIFY;
          end
        end
      end
      VERIFY: begin
        if (w_hit) begin
          w_match_nxt = r_match + 4'd1;
          w_idx_nxt   = w_dec_idx;
          if (r_match + 4'd1 == LOCK_N) begin
            w_state_nxt  = LOCKED;
            w_locked_nxt = 1'b1;
            w_mode_o_nxt = w_dec_mode;
            w_phase_nxt  = w_dec_idx;
          end
        end else if (w_pair_vld && w_pair_ok) begin
          w_mode_nxt  = w_dec_mode;
          w_idx_nxt   = w_dec_idx;
          w_match_nxt = 4'd1;
        end else begin
          w_state_nxt = SEARCH;
          w_match_nxt = 4'd0;
        end
      end
      LOCKED: begin
        if (w_hit) begin
          w_idx_nxt    = w_dec_idx;
          w_mode_o_nxt = w_dec_mode;
          w_phase_nxt  = w_dec_idx;
          if (w_dec_idx == 4'd0) w_seq_nxt = r_seq + 8'd1;
        end else begin
          w_err_nxt    = 1'b1;
          if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
          w_locked_nxt = 1'b0;
          w_mode_o_nxt = 1'b0;
          w_phase_nxt  = 4'd0;
          w_match_nxt  = 4'd0;
          w_state_nxt  = SEARCH;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_match_nxt = 4'd0;
      end
    endcase
  end

  assign bus.locked  = r_locked;
  assign bus.mode_o  = r_mode_o;
  assign bus.phase_o = r_phase;
  assign bus.err_o   = r_err;
  assign bus.err_cnt = r_err_cnt;
  assign bus.seq_cnt = r_seq;

endmodule

// File: tb/tb_led_pattern_checker.sv
// Bench for led_pattern_checker: a reference model predicts the outputs of
// every edge into a scoreboard queue; directed checks cover the lock timing,
// error, saturation, wrap and asynchronous reset cases.
module tb_led_pattern_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  led_pattern_checker_if bus0 ();
  led_pattern_checker_if bus1 ();

  led_pattern_checker #(.LOCK_CNT(3)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  led_pattern_checker #(.LOCK_CNT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  localparam int LOCK = 3;
  localparam logic [11:0] FT [7]  = '{12'h000, 12'h060, 12'h0F0, 12'h1F8,
                                      12'h3FC, 12'h7FE, 12'hFFF};
  localparam logic [11:0] BT [10] = '{12'h801, 12'h402, 12'h204, 12'h108, 12'h090,
                                      12'h060, 12'h090, 12'h108, 12'h204, 12'h402};

  typedef struct packed {
    logic       locked;
    logic       mode;
    logic [3:0] phase;
    logic       err;
    logic [7:0] ec;
    logic [7:0] sc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [11:0] m_prv, m_cur;
  int          m_fill, m_st, m_cnt, m_idx;
  bit          m_mode;
  exp_t        m_out;

  function automatic void mdl_reset();
    m_prv = 12'h000; m_cur = 12'h000;
    m_fill = 0; m_st = 0; m_cnt = 0; m_idx = 0; m_mode = 1'b0;
    m_out = '0;
    sb.delete();
  endfunction

  function automatic void mdl_decode(input logic [11:0] p, input logic [11:0] c,
                                     output bit ok, output bit md, output int ix);
    ok = 1'b0; md = 1'b0; ix = 0;
    for (int j = 0; j < 7; j++)
      if (FT[j] == p && FT[(j + 1) % 7] == c) begin ok = 1'b1; md = 1'b1; ix = (j + 1) % 7; end
    for (int j = 0; j < 10; j++)
      if (BT[j] == p && BT[(j + 1) % 10] == c) begin ok = 1'b1; md = 1'b0; ix = (j + 1) % 10; end
  endfunction

  function automatic void mdl_edge(input logic [11:0] pat);
    bit ok, md, hit;
    int ix, nx;
    mdl_decode(m_prv, m_cur, ok, md, ix);
    nx  = m_mode ? (m_idx + 1) % 7 : (m_idx + 1) % 10;
    hit = (m_fill == 2) && ok && (md == m_mode) && (ix == nx);
    m_out.err = 1'b0;
    if (m_st == 0) begin
      if (m_fill == 2 && ok) begin
        m_mode = md; m_idx = ix; m_cnt = 1;
        if (LOCK == 1) begin
          m_st = 2; m_out.locked = 1'b1; m_out.mode = md; m_out.phase = 4'(ix);
        end else m_st = 1;
      end
    end else if (m_st == 1) begin
      if (hit) begin
        m_cnt++; m_idx = ix;
        if (m_cnt == LOCK) begin
          m_st = 2; m_out.locked = 1'b1; m_out.mode = md; m_out.phase = 4'(ix);
        end
      end else if (ok) begin
        m_mode = md; m_idx = ix; m_cnt = 1;
      end else begin
        m_st = 0; m_cnt = 0;
      end
    end else begin
      if (hit) begin
        m_idx = ix; m_out.mode = md; m_out.phase = 4'(ix);
        if (ix == 0) m_out.sc = m_out.sc + 8'd1;
      end else begin
        m_out.err = 1'b1;
        if (m_out.ec != 8'd255) m_out.ec = m_out.ec + 8'd1;
        m_out.locked = 1'b0; m_out.mode = 1'b0; m_out.phase = 4'd0;
        m_cnt = 0; m_st = 0;
      end
    end
    if (m_fill < 2) m_fill++;
    m_prv = m_cur;
    m_cur = pat;
    sb.push_back(m_out);
  endfunction

  // Drive one pattern (clock low), let one rising edge pass, check the queue head.
  task automatic step(input logic [11:0] pat);
    exp_t e, o;
    bus0.led_i = pat;
    bus1.led_i = pat;
    mdl_edge(pat);
    @(posedge clk);
    #1;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
    end else begin
      e = sb.pop_front();
      o = {bus0.locked, bus0.mode_o, bus0.phase_o, bus0.err_o, bus0.err_cnt, bus0.seq_cnt};
      if (o !== e) begin
        miscompares++;
        $display("FAIL stream t=%0t: got locked=%b mode=%b phase=%0d err=%b err_cnt=%0d seq_cnt=%0d, want locked=%b mode=%b phase=%0d err=%b err_cnt=%0d seq_cnt=%0d",
                 $time, o.locked, o.mode, o.phase, o.err, o.ec, o.sc,
                 e.locked, e.mode, e.phase, e.err, e.ec, e.sc);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus0.led_i = 12'h000;
    bus1.led_i = 12'h000;
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int bi;

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.led_i = 12'h000;
    bus1.led_i = 12'h000;
    mdl_reset();
    @(negedge clk);
    vectors++;
    if ({bus0.locked, bus0.mode_o, bus0.phase_o, bus0.err_o, bus0.err_cnt, bus0.seq_cnt} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got locked=%b phase=%0d err_cnt=%0d seq_cnt=%0d, want all 0",
               bus0.locked, bus0.phase_o, bus0.err_cnt, bus0.seq_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_bounce_lock();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(BT[i]);
      if (i == 3) begin
        vectors++;
        if (bus0.locked !== 1'b0) begin
          miscompares++;
          $display("FAIL bounce_early_lock: locked=%b after edge 4, want 0", bus0.locked);
        end
      end
    end
    vectors++;
    if ({bus0.locked, bus0.mode_o, bus0.phase_o} !== {1'b1, 1'b0, 4'd3}) begin
      miscompares++;
      $display("FAIL bounce_lock_edge5: locked=%b mode=%b phase=%0d, want 1 0 3",
               bus0.locked, bus0.mode_o, bus0.phase_o);
    end
    for (int i = 5; i < 10; i++) step(BT[i]);
    step(BT[0]);
    vectors++;
    if (bus0.seq_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL bounce_seq_early: seq_cnt=%0d when 801 captured, want 0", bus0.seq_cnt);
    end
    step(BT[1]);
    vectors++;
    if (bus0.seq_cnt !== 8'd1 || bus0.err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL bounce_seq: seq_cnt=%0d err_cnt=%0d, want 1 0", bus0.seq_cnt, bus0.err_cnt);
    end
    bi = 2;
  endtask

  task automatic test_error_inject();
    int k;
    step(12'h0F0);
    bi = 3;
    step(BT[bi]); bi++;
    vectors++;
    if ({bus0.err_o, bus0.err_cnt, bus0.locked} !== {1'b1, 8'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL inject_err: err=%b err_cnt=%0d locked=%b, want 1 1 0",
               bus0.err_o, bus0.err_cnt, bus0.locked);
    end
    k = 0;
    while (bus0.locked !== 1'b1 && k < 12) begin
      step(BT[bi]); bi = (bi + 1) % 10; k++;
      if (k == 1) begin
        vectors++;
        if (bus0.err_o !== 1'b0) begin
          miscompares++;
          $display("FAIL inject_pulse_width: err=%b one cycle later, want 0", bus0.err_o);
        end
      end
    end
    vectors++;
    if (k != 4) begin
      miscompares++;
      $display("FAIL inject_relock: relocked after %0d edges past the error, want 4", k);
    end
  endtask

  task automatic test_mode_switch();
    while (bi != 2) begin step(BT[bi]); bi = (bi + 1) % 10; end
    step(FT[0]);
    step(FT[1]);
    vectors++;
    if ({bus0.err_o, bus0.err_cnt, bus0.locked} !== {1'b1, 8'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL switch_err: err=%b err_cnt=%0d locked=%b, want 1 2 0",
               bus0.err_o, bus0.err_cnt, bus0.locked);
    end
    for (int i = 2; i < 5; i++) step(FT[i]);
    vectors++;
    if ({bus0.locked, bus0.mode_o, bus0.phase_o, bus0.seq_cnt} !== {1'b1, 1'b1, 4'd3, 8'd2}) begin
      miscompares++;
      $display("FAIL switch_relock: locked=%b mode=%b phase=%0d seq_cnt=%0d, want 1 1 3 2",
               bus0.locked, bus0.mode_o, bus0.phase_o, bus0.seq_cnt);
    end
  endtask

  task automatic test_fill_lock();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step(FT[i % 7]);
      if (i == 4) begin
        vectors++;
        if ({bus0.locked, bus0.mode_o, bus0.phase_o} !== {1'b1, 1'b1, 4'd3}) begin
          miscompares++;
          $display("FAIL fill_lock: locked=%b mode=%b phase=%0d, want 1 1 3",
                   bus0.locked, bus0.mode_o, bus0.phase_o);
        end
      end
      if (i == 8) begin
        vectors++;
        if (bus0.seq_cnt !== 8'd1) begin
          miscompares++;
          $display("FAIL fill_wrap: seq_cnt=%0d after FFF->000, want 1", bus0.seq_cnt);
        end
      end
      if (i == 9) begin
        vectors++;
        if ({bus0.mode_o, bus0.phase_o} !== {1'b1, 4'd1}) begin
          miscompares++;
          $display("FAIL fill_ambiguous_060: mode=%b phase=%0d, want 1 1", bus0.mode_o, bus0.phase_o);
        end
      end
    end
    vectors++;
    if (bus0.seq_cnt !== 8'd3) begin
      miscompares++;
      $display("FAIL fill_seq_total: seq_cnt=%0d, want 3", bus0.seq_cnt);
    end
  endtask

  task automatic test_err_saturation();
    int pulses = 0;
    logic [11:0] cyc [5];
    cyc = '{12'h801, 12'h402, 12'h204, 12'h108, 12'h000};
    do_reset();
    for (int c = 0; c < 260; c++)
      for (int j = 0; j < 5; j++) begin
        step(cyc[j]);
        if (bus0.err_o === 1'b1) pulses++;
      end
    step(12'h801);
    if (bus0.err_o === 1'b1) pulses++;
    vectors++;
    if (pulses != 260 || bus0.err_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL err_saturation: pulses=%0d err_cnt=%0d, want 260 255", pulses, bus0.err_cnt);
    end
  endtask

  task automatic test_seq_wrap();
    bit saw_wrap = 1'b0;
    logic [7:0] last = 8'd0;
    do_reset();
    for (int i = 0; i < 1820; i++) begin
      step(FT[i % 7]);
      if (last == 8'd255 && bus0.seq_cnt == 8'd0) saw_wrap = 1'b1;
      last = bus0.seq_cnt;
    end
    vectors++;
    if (!saw_wrap || bus0.seq_cnt !== 8'd3) begin
      miscompares++;
      $display("FAIL seq_wrap: saw_wrap=%b seq_cnt=%0d, want 1 3", saw_wrap, bus0.seq_cnt);
    end
  endtask

  task automatic test_async_reset_lock1();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(BT[i]);
      if (i == 1) begin
        vectors++;
        if (bus1.locked !== 1'b0) begin
          miscompares++;
          $display("FAIL lock1_early: locked=%b after edge 2, want 0", bus1.locked);
        end
      end
      if (i == 2) begin
        vectors++;
        if ({bus1.locked, bus1.mode_o, bus1.phase_o} !== {1'b1, 1'b0, 4'd1}) begin
          miscompares++;
          $display("FAIL lock1_edge3: locked=%b mode=%b phase=%0d, want 1 0 1",
                   bus1.locked, bus1.mode_o, bus1.phase_o);
        end
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus0.locked, bus0.mode_o, bus0.phase_o, bus0.err_o, bus0.err_cnt, bus0.seq_cnt,
         bus1.locked, bus1.phase_o} !== 28'd0) begin
      miscompares++;
      $display("FAIL async_reset: locked=%b phase=%0d lock1=%b, want all 0 before any edge",
               bus0.locked, bus0.phase_o, bus1.locked);
    end
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(BT[i]);
    vectors++;
    if (bus0.locked !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_relock: locked=%b, want 1", bus0.locked);
    end
  endtask

  initial begin
    bus0.led_i = 12'h000;
    bus1.led_i = 12'h000;
    test_reset();
    test_bounce_lock();
    test_error_inject();
    test_mode_switch();
    test_fill_lock();
    test_err_saturation();
    test_seq_wrap();
    test_async_reset_lock1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
